// File: rtl/clkgen_pkg.sv
// Shared FSM state type, default constants and sizing helper for the
// multi-channel fractional clock-enable generator.
package clkgen_pkg;

  typedef enum logic [1:0] {
    S_INIT,
    S_LOCKED,
    S_RELOCK
  } state_t;

  // 0.63 * 2^32: a 31.5 MHz average enable rate from a 50 MHz reference.
  localparam logic [47:0] DEF_INIT_INC    = 48'd2705829396;
  localparam int          DEF_LOCK_CYCLES = 1024;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clkgen_frac_multi_if.sv
// Configuration port of the clock-enable generator: a valid/ready request
// carrying channel, increment and phase-clear, plus a bad-channel error pulse.
interface clkgen_frac_multi_if #(
  parameter int ACC_W = 32
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_chan;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_phase_rst;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_inc,
    output cfg_phase_rst,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_inc,
    input  cfg_phase_rst,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clkgen_phase_acc.sv
// One phase-accumulator channel: registered carry strobe and MSB square wave,
// with a runtime-loadable increment and optional accumulator clear.
module clkgen_phase_acc #(
  parameter int               ACC_W    = 32,
  parameter logic [ACC_W-1:0] INIT_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_phase_clr,
  input  logic [ACC_W-1:0] i_inc,
  output logic             o_en,
  output logic             o_sq
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic             r_en;
  logic             r_sq;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

  // The add on a load edge still uses the old increment; a phase clear
  // replaces that edge's add entirely, so no strobe can come from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_inc <= INIT_INC;
      r_en  <= 1'b0;
      r_sq  <= 1'b0;
    end else begin
      if (i_load) r_inc <= i_inc;
      if (i_load && i_phase_clr) begin
        r_acc <= '0;
        r_en  <= 1'b0;
        r_sq  <= 1'b0;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
        r_en  <= w_sum[ACC_W];
        r_sq  <= w_sum[ACC_W-1];
      end
    end
  end

  assign o_en = r_en;
  assign o_sq = r_sq;

endmodule

// File: rtl/clkgen_frac_multi.sv
// N-channel fractional clock-enable generator: per-channel phase accumulators,
// a reconfiguration handshake and a lock FSM that gates outputs while settling.
module clkgen_frac_multi
  import clkgen_pkg::*;
#(
  parameter int               NUM_CH        = 2,
  parameter int               ACC_W         = 32,
  parameter logic [ACC_W-1:0] INIT_INC      = DEF_INIT_INC[ACC_W-1:0],
  parameter int               LOCK_CYCLES   = DEF_LOCK_CYCLES,
  parameter bit               GATE_UNLOCKED = 1'b1
) (
  input  logic                refclk,
  input  logic                rst,
  clkgen_frac_multi_if.slave  cfg,
  output logic [NUM_CH-1:0]   en_out,
  output logic [NUM_CH-1:0]   sq_out,
  output logic                locked
);

  localparam int               CNT_W   = clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  logic              r_ready;
  logic              r_locked;
  logic              r_err;
  logic              w_xfer;
  logic              w_chan_ok;
  logic              w_accept;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_en_raw;
  logic [NUM_CH-1:0] w_sq_raw;

  assign w_xfer    = cfg.cfg_valid & r_ready;
  assign w_chan_ok = int'(cfg.cfg_chan) < NUM_CH;
  assign w_accept  = w_xfer & w_chan_ok;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_load[c] = w_accept && (cfg.cfg_chan == 4'(c));

    clkgen_phase_acc #(
      .ACC_W    (ACC_W),
      .INIT_INC (INIT_INC)
    ) u_acc (
      .clk         (refclk),
      .rst         (rst),
      .i_load      (w_load[c]),
      .i_phase_clr (cfg.cfg_phase_rst),
      .i_inc       (cfg.cfg_inc),
      .o_en        (w_en_raw[c]),
      .o_sq        (w_sq_raw[c])
    );
  end

  // Any accepted request restarts the settle count, even one arriving
  // while the count from reset is still running.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (w_accept) begin
      w_next_state = S_RELOCK;
      w_next_cnt   = '0;
    end else begin
      unique case (r_state)
        S_INIT, S_RELOCK: begin
          if (r_cnt == CNT_MAX) w_next_state = S_LOCKED;
          else                  w_next_cnt   = r_cnt + 1'b1;
        end
        S_LOCKED: begin
          w_next_state = S_LOCKED;
        end
        default: begin
          w_next_state = S_INIT;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so that cfg_ready
  // stays low while reset is held and only rises after the first edge.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state  <= S_INIT;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_ready  <= (w_next_state != S_RELOCK);
      r_locked <= (w_next_state == S_LOCKED);
      r_err    <= w_xfer & ~w_chan_ok;
    end
  end

  assign cfg.cfg_ready = r_ready;
  assign cfg.cfg_err   = r_err;
  assign locked        = r_locked;

  if (GATE_UNLOCKED) begin : g_gate
    assign en_out = w_en_raw & {NUM_CH{r_locked}};
    assign sq_out = w_sq_raw & {NUM_CH{r_locked}};
  end else begin : g_nogate
    assign en_out = w_en_raw;
    assign sq_out = w_sq_raw;
  end

endmodule

// File: tb/tb_clkgen_frac_multi.sv
// Self-checking bench for clkgen_frac_multi: directed handshake scenarios plus
// random reconfiguration, compared cycle by cycle against an arithmetic model.
module tb_clkgen_frac_multi;

  localparam int         NUM_CH = 2;
  localparam int         ACC_W  = 8;
  localparam int         LOCK   = 8;
  localparam int         MOD    = 256;
  localparam logic [7:0] INC0   = 8'd64;

  logic              refclk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] sq_out;
  logic              locked;

  clkgen_frac_multi_if #(.ACC_W(ACC_W)) cfg ();

  clkgen_frac_multi #(
    .NUM_CH        (NUM_CH),
    .ACC_W         (ACC_W),
    .INIT_INC      (INC0),
    .LOCK_CYCLES   (LOCK),
    .GATE_UNLOCKED (1'b1)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .cfg    (cfg),
    .en_out (en_out),
    .sq_out (sq_out),
    .locked (locked)
  );

  always #5 refclk = ~refclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase kept as an integer in [0, 256), lock status as a
  // count of edges since reset release or since the last accepted request.
  int mAcc [NUM_CH];
  int mInc [NUM_CH];
  bit mEn  [NUM_CH];
  bit mSq  [NUM_CH];
  int mLockCnt;
  bit mRelock;
  bit mStarted;
  bit mErr;

  function automatic bit modelLocked();
    return mLockCnt >= LOCK;
  endfunction

  function automatic bit modelReady();
    return mStarted && !(mRelock && mLockCnt < LOCK);
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      mAcc[c] = 0;
      mInc[c] = int'(INC0);
      mEn[c]  = 1'b0;
      mSq[c]  = 1'b0;
    end
    mLockCnt = 0;
    mRelock  = 1'b0;
    mStarted = 1'b0;
    mErr     = 1'b0;
  endtask

  task automatic modelEdge();
    bit xfer, ok, accept;
    int chan, sum;
    xfer   = cfg.cfg_valid && modelReady();
    chan   = int'(cfg.cfg_chan);
    ok     = chan < NUM_CH;
    accept = xfer && ok;
    for (int c = 0; c < NUM_CH; c++) begin
      sum = mAcc[c] + mInc[c];
      if (accept && chan == c && cfg.cfg_phase_rst) begin
        mAcc[c] = 0;
        mEn[c]  = 1'b0;
      end else begin
        mEn[c]  = sum >= MOD;
        mAcc[c] = sum % MOD;
      end
      mSq[c] = mAcc[c] >= MOD / 2;
      if (accept && chan == c) mInc[c] = int'(cfg.cfg_inc);
    end
    if (accept) begin
      mLockCnt = 0;
      mRelock  = 1'b1;
    end else if (mLockCnt < LOCK) begin
      mLockCnt++;
    end
    mErr     = xfer && !ok;
    mStarted = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string ctx);
    logic [NUM_CH-1:0] expEn, expSq;
    for (int c = 0; c < NUM_CH; c++) begin
      expEn[c] = modelLocked() && mEn[c];
      expSq[c] = modelLocked() && mSq[c];
    end
    checkOutput({ctx, ".locked"}, 32'(locked), 32'(modelLocked()));
    checkOutput({ctx, ".ready"},  32'(cfg.cfg_ready), 32'(modelReady()));
    checkOutput({ctx, ".err"},    32'(cfg.cfg_err), 32'(mErr));
    checkOutput({ctx, ".en"},     32'(en_out), 32'(expEn));
    checkOutput({ctx, ".sq"},     32'(sq_out), 32'(expSq));
  endtask

  task automatic applyStimulus(input string ctx, input bit valid, input int chan,
                               input int inc, input bit phase);
    cfg.cfg_valid     = valid;
    cfg.cfg_chan      = 4'(chan);
    cfg.cfg_inc       = 8'(inc);
    cfg.cfg_phase_rst = phase;
    @(posedge refclk);
    modelEdge();
    #1;
    checkAll(ctx);
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) applyStimulus(ctx, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic sendCfg(input string ctx, input int chan, input int inc, input bit phase);
    int waited;
    waited = 0;
    while (!modelReady() && waited < 40) begin
      applyStimulus({ctx, ".wait"}, 1'b0, 0, 0, 1'b0);
      waited++;
    end
    if (!modelReady()) checkOutput({ctx, ".readyTimeout"}, 32'(cfg.cfg_ready), 32'd1);
    else               applyStimulus(ctx, 1'b1, chan, inc, phase);
  endtask

  task automatic randomRun(input string ctx, input int n);
    bit v, p;
    int ch, inc;
    for (int i = 0; i < n; i++) begin
      v   = $urandom_range(0, 9) == 0;
      ch  = $urandom_range(0, 3);
      inc = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      p   = $urandom_range(0, 1) == 1;
      applyStimulus(ctx, v, ch, inc, p);
    end
  endtask

  initial begin
    cfg.cfg_valid     = 1'b0;
    cfg.cfg_chan      = 4'd0;
    cfg.cfg_inc       = 8'd0;
    cfg.cfg_phase_rst = 1'b0;
    rst = 1'b1;
    modelReset();
    #12;
    checkAll("reset");
    @(negedge refclk);
    rst = 1'b0;

    idle("lockUp", 14);
    sendCfg("reconfCh1", 1, 32, 1'b0);
    idle("relock", 20);
    sendCfg("phaseRst", 0, 64, 1'b1);
    idle("afterPhase", 14);
    sendCfg("badChan", 5, 99, 1'b0);
    idle("afterBad", 6);
    sendCfg("stopCh1", 1, 0, 1'b0);
    idle("stopped", 20);
    sendCfg("oddInc", 0, 200, 1'b0);
    idle("oddRun", 20);
    randomRun("rand1", 500);

    sendCfg("preRst", 0, 48, 1'b0);
    idle("preRstRelock", 3);
    #4;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("asyncRst");
    @(negedge refclk);
    rst = 1'b0;
    idle("postRst", 20);
    randomRun("rand2", 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clkgen_frac_multi.md
Name: clkgen_frac_multi

Overview:
- Parametrised N-channel fractional clock-enable generator running on one reference clock. Supersedes fixed single-output clock generation.
- Each channel is a phase accumulator. It produces a one-cycle enable strobe and a square-wave phase bit at f_ref * inc / 2^ACC_W.
- Increments can be reprogrammed at runtime through a valid/ready port. A lock FSM reports when outputs are stable.
- Sits between board clock input and pixel/timing logic, e.g. a 31.5 MHz-average pixel enable from 50 MHz.

Parameters:
- NUM_CH, 2, number of output channels (1..16).
- ACC_W, 32, accumulator width in bits (8..48).
- INIT_INC, 2705829396, reset increment for every channel; equals 0.63 * 2^32, i.e. 31.5 MHz from 50 MHz.
- LOCK_CYCLES, 1024, settle cycles before locked asserts (>=2).
- GATE_UNLOCKED, 1, when 1 en_out/sq_out are forced 0 while locked=0.

Ports:
- refclk  in  1  reference clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration can be accepted this cycle.
- cfg_chan  in  4  target channel index.
- cfg_inc  in  ACC_W  new increment.
- cfg_phase_rst  in  1  also clear the target accumulator to 0.
- cfg_err  out  1  one-cycle pulse: accepted request had cfg_chan >= NUM_CH.
- en_out  out  NUM_CH  per-channel one-cycle enable strobe.
- sq_out  out  NUM_CH  per-channel accumulator MSB, registered.
- locked  out  1  outputs settled at current configuration.

Behaviour:
- Reset, asynchronous, active-high:
  - All accumulators = 0; all inc = INIT_INC.
  - en_out = 0, sq_out = 0, locked = 0, cfg_err = 0, cfg_ready = 0.
  - FSM = S_INIT, lock counter = 0.
- Accumulator, every edge, per channel c:
  - acc[c] <= (acc[c] + inc[c]) mod 2^ACC_W.
  - en_out[c] <= carry-out of that add; high exactly one cycle per wrap.
  - sq_out[c] <= new acc[c][ACC_W-1].
  - Latency: en_out is high in the cycle after the edge on which the wrap occurred.
- Increment edge cases:
  - inc = 0: channel stopped; en_out stays 0 and sq_out holds.
  - sq_out duty is meaningful only for inc <= 2^(ACC_W-1). en_out is valid for any inc.
- FSM:
  - S_INIT: counter increments each edge. When it reaches LOCK_CYCLES-1, next state is S_LOCKED, so locked is high on the LOCK_CYCLES-th edge after reset deassertion. cfg_ready = 1.
  - S_LOCKED: locked = 1, cfg_ready = 1.
  - S_RELOCK: locked = 0, cfg_ready = 0. Counter cleared on entry and runs as in S_INIT, so locked rises LOCK_CYCLES edges after the accepting edge.
- Handshake:
  - A transfer happens on an edge where cfg_valid & cfg_ready.
  - Valid chan: inc[chan] <= cfg_inc. If cfg_phase_rst, acc[chan] <= 0, and that channel's add is suppressed on that edge. Then go to S_RELOCK.
  - Valid chan, next cycle: locked = 0, cfg_ready = 0.
  - Invalid chan: no state change, no relock, cfg_err = 1 for the next cycle only.
  - Transfer accepted in S_INIT: moves to S_RELOCK and restarts the count.
- GATE_UNLOCKED = 1: outputs are masked combinationally by the registered locked. Accumulators keep running while masked.
- cfg_valid while cfg_ready = 0: ignored. The requester must hold the request.
- Reset mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Package clkgen_pkg:
  - FSM state enum {S_INIT, S_LOCKED, S_RELOCK}.
  - Default constants: INIT_INC value for 50 MHz to 31.5 MHz, and LOCK_CYCLES.
  - Lock counter width function clog2(LOCK_CYCLES).
- Sub-module clkgen_phase_acc: one accumulator channel (acc, inc, load/phase-clear, carry/MSB registers), instantiated NUM_CH times.
- Top holds the FSM, handshake and gating.

Test Plan:
- Lock after reset (ACC_W=8, INC=64, LOCK_CYCLES=8): release rst -> locked rises on 8th edge; en_out[0] period 4, high one cycle; sq_out[0] 2 high / 2 low.
- Reconfigure: in S_LOCKED send chan=1, inc=32 -> cfg_ready=0 and locked=0 next cycle; locked back after 8 edges; en_out[1] period 8.
- Phase reset: send chan=0, inc=64, cfg_phase_rst=1 -> acc[0]=0 after accept edge; first en_out[0] pulse exactly 4 cycles after accept.
- Invalid channel: NUM_CH=2, cfg_chan=5 -> cfg_err one cycle; locked stays 1; all inc unchanged.
- Stopped channel and gating: inc=0 -> en_out never asserts; during S_RELOCK with GATE_UNLOCKED=1 all en_out/sq_out read 0.
- Async reset mid-relock: assert rst between edges -> locked, en_out, sq_out, cfg_ready go 0 immediately; inc returns to INIT_INC.
